multicycle_ctrl: RTL and testbench

//  Moore-style control FSM that sequences the RV32I datapath over multiple cycles.
//  - Drives the ALU operand selects: ALUSrcA (rs1 vs PC) and ALUSrcB (rs2 vs imm).
//  - Drives ALU op class, PC/IR/register-file write enables and memory requests.
//  - Sits between the instruction register/decoder and the datapath muxes.
//  - Stalls on memory-ready handshakes; counts retired instructions.

---
 rtl/multicycle_ctrl.sv | 172 +++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM: Moore decode of datapath selects/enables from state,
// with ready-gated IR load, load exit and store completion. Counts retired instructions.
module multicycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic             branch_taken,
    input  logic             instr_ready,
    input  logic             data_ready,
    output logic             ALUSrcA,
    output logic             ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic             InstrReq,
    output logic             IRWrite,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             RegWrite,
    output logic [1:0]       ResultSrc,
    output logic             PCWrite,
    output logic             PCSrc,
    output logic             illegal,
    output logic [CNT_W-1:0] instret,
    output logic [3:0]       state_dbg
);

    localparam logic [3:0] FETCH   = 4'd0;
    localparam logic [3:0] DECODE  = 4'd1;
    localparam logic [3:0] EXEC_R  = 4'd2;
    localparam logic [3:0] EXEC_I  = 4'd3;
    localparam logic [3:0] LUI     = 4'd4;
    localparam logic [3:0] AUIPC   = 4'd5;
    localparam logic [3:0] WB_ALU  = 4'd6;
    localparam logic [3:0] MEM_ADR = 4'd7;
    localparam logic [3:0] MEM_RD  = 4'd8;
    localparam logic [3:0] MEM_WB  = 4'd9;
    localparam logic [3:0] MEM_WR  = 4'd10;
    localparam logic [3:0] BR_CMP  = 4'd11;
    localparam logic [3:0] BR_TGT  = 4'd12;
    localparam logic [3:0] JAL     = 4'd13;
    localparam logic [3:0] JALR    = 4'd14;
    localparam logic [3:0] TRAP    = 4'd15;

    logic [3:0] state, state_nx;
    logic [6:0] opcode_q;
    logic       taken_q;
    logic       sel_a_q, sel_b_q;
    logic [1:0] sel_op_q;
    logic       ld_sel;

    assign state_dbg = state;

    always_comb begin
        state_nx  = state;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 1'b0;
        ALUOp     = 2'b00;
        InstrReq  = 1'b0;
        IRWrite   = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        RegWrite  = 1'b0;
        ResultSrc = 2'b00;
        PCWrite   = 1'b0;
        PCSrc     = 1'b0;
        ld_sel    = 1'b0;
        case (state)
            FETCH: begin
                InstrReq = 1'b1;
                IRWrite  = instr_ready;
                if (instr_ready) state_nx = DECODE;
            end
            DECODE: begin
                case (opcode)
                    7'b0110011: state_nx = EXEC_R;
                    7'b0010011: state_nx = EXEC_I;
                    7'b0000011,
                    7'b0100011: state_nx = MEM_ADR;
                    7'b1100011: state_nx = BR_CMP;
                    7'b1101111: state_nx = JAL;
                    7'b1100111: state_nx = JALR;
                    7'b0110111: state_nx = LUI;
                    7'b0010111: state_nx = AUIPC;
                    default:    state_nx = TRAP;
                endcase
            end
            EXEC_R: begin
                ALUOp = 2'b10; ld_sel = 1'b1; state_nx = WB_ALU;
            end
            EXEC_I: begin
                ALUSrcB = 1'b1; ALUOp = 2'b10; ld_sel = 1'b1; state_nx = WB_ALU;
            end
            LUI: begin
                ALUSrcB = 1'b1; ALUOp = 2'b11; ld_sel = 1'b1; state_nx = WB_ALU;
            end
            AUIPC: begin
                ALUSrcA = 1'b1; ALUSrcB = 1'b1; ld_sel = 1'b1; state_nx = WB_ALU;
            end
            WB_ALU: begin
                ALUSrcA = sel_a_q; ALUSrcB = sel_b_q; ALUOp = sel_op_q;
                RegWrite = 1'b1; PCWrite = 1'b1;
                state_nx = FETCH;
            end
            MEM_ADR: begin
                // opcode bit 5 separates store (0100011) from load (0000011)
                ALUSrcB = 1'b1; ld_sel = 1'b1;
                state_nx = opcode_q[5] ? MEM_WR : MEM_RD;
            end
            MEM_RD: begin
                ALUSrcA = sel_a_q; ALUSrcB = sel_b_q; ALUOp = sel_op_q;
                MemRead = 1'b1;
                if (data_ready) state_nx = MEM_WB;
            end
            MEM_WB: begin
                RegWrite = 1'b1; ResultSrc = 2'b01; PCWrite = 1'b1;
                state_nx = FETCH;
            end
            MEM_WR: begin
                ALUSrcA = sel_a_q; ALUSrcB = sel_b_q; ALUOp = sel_op_q;
                MemWrite = 1'b1;
                PCWrite  = data_ready;
                if (data_ready) state_nx = FETCH;
            end
            BR_CMP: begin
                ALUOp = 2'b01; state_nx = BR_TGT;
            end
            BR_TGT: begin
                ALUSrcA = 1'b1; ALUSrcB = 1'b1;
                PCWrite = 1'b1; PCSrc = taken_q;
                state_nx = FETCH;
            end
            JAL: begin
                ALUSrcA = 1'b1; ALUSrcB = 1'b1;
                RegWrite = 1'b1; ResultSrc = 2'b10; PCWrite = 1'b1; PCSrc = 1'b1;
                state_nx = FETCH;
            end
            JALR: begin
                ALUSrcB = 1'b1;
                RegWrite = 1'b1; ResultSrc = 2'b10; PCWrite = 1'b1; PCSrc = 1'b1;
                state_nx = FETCH;
            end
            default: state_nx = TRAP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FETCH;
            opcode_q <= '0;
            taken_q  <= 1'b0;
            sel_a_q  <= 1'b0;
            sel_b_q  <= 1'b0;
            sel_op_q <= 2'b00;
            illegal  <= 1'b0;
            instret  <= '0;
        end else begin
            state <= state_nx;
            if (state == DECODE) opcode_q <= opcode;
            if (state == BR_CMP) taken_q <= branch_taken;
            // capture the exec-state operand selects so writeback/memory states hold them
            if (ld_sel) begin
                sel_a_q  <= ALUSrcA;
                sel_b_q  <= ALUSrcB;
                sel_op_q <= ALUOp;
            end
            if (state_nx == TRAP) illegal <= 1'b1;
            if (PCWrite) instret <= instret + 1'b1;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: hand-computed state/output vectors per cycle.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  opcode;
    logic        branch_taken, instr_ready, data_ready;
    logic        ALUSrcA, ALUSrcB, InstrReq, IRWrite, MemRead, MemWrite, RegWrite;
    logic        PCWrite, PCSrc, illegal;
    logic [1:0]  ALUOp, ResultSrc;
    logic [31:0] instret;
    logic [3:0]  state_dbg;

    int n_chk = 0;
    int n_err = 0;

    multicycle_ctrl #(.CNT_W(32)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .branch_taken(branch_taken),
        .instr_ready(instr_ready), .data_ready(data_ready),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .InstrReq(InstrReq),
        .IRWrite(IRWrite), .MemRead(MemRead), .MemWrite(MemWrite), .RegWrite(RegWrite),
        .ResultSrc(ResultSrc), .PCWrite(PCWrite), .PCSrc(PCSrc), .illegal(illegal),
        .instret(instret), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // advance one clock; inputs are driven after the edge, outputs sampled 1ns later
    task automatic cyc;
        @(posedge clk);
        #2;
    endtask

    // {InstrReq, IRWrite, MemRead, MemWrite, RegWrite, PCWrite}
    function automatic logic [31:0] en();
        return {26'd0, InstrReq, IRWrite, MemRead, MemWrite, RegWrite, PCWrite};
    endfunction

    // {ALUSrcA, ALUSrcB, ALUOp, ResultSrc, PCSrc}
    function automatic logic [31:0] sel();
        return {25'd0, ALUSrcA, ALUSrcB, ALUOp, ResultSrc, PCSrc};
    endfunction

    // one cycle in FETCH with instruction ready, then DECODE with the given opcode
    task automatic fetch_decode(input logic [6:0] op, input string tag);
        instr_ready = 1'b1; opcode = op; #1;
        chk({tag, ".fetch_st"}, state_dbg, 0);
        chk({tag, ".fetch_en"}, en(), 6'b110000);
        cyc; #1;
        chk({tag, ".decode_st"}, state_dbg, 1);
        chk({tag, ".decode_en"}, en(), 0);
        cyc;
    endtask

    initial begin
        rst = 1'b1; opcode = 7'd0; branch_taken = 1'b0;
        instr_ready = 1'b0; data_ready = 1'b0;
        cyc; cyc;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc; #1;
            chk("idle.st", state_dbg, 0);
            chk("idle.en", en(), 6'b100000);
            chk("idle.sel", sel(), 0);
            chk("idle.instret", instret, 0);
            chk("idle.illegal", {31'd0, illegal}, 0);
        end

        // R-type add: 4 cycles
        cyc;
        fetch_decode(7'b0110011, "rtype");
        #1;
        chk("rtype.exec_st", state_dbg, 2);
        chk("rtype.exec_sel", sel(), 7'b00_10_00_0);
        cyc; #1;
        chk("rtype.wb_st", state_dbg, 6);
        chk("rtype.wb_en", en(), 6'b000011);
        chk("rtype.wb_sel", sel(), 7'b00_10_00_0);
        cyc; #1;
        chk("rtype.done_st", state_dbg, 0);
        chk("rtype.instret", instret, 1);

        // Load with data_ready low 3 cycles: 8 cycles total
        fetch_decode(7'b0000011, "load");
        data_ready = 1'b0; #1;
        chk("load.adr_st", state_dbg, 7);
        chk("load.adr_sel", sel(), 7'b01_00_00_0);
        for (int i = 0; i < 3; i++) begin
            cyc; #1;
            chk("load.wait_st", state_dbg, 8);
            chk("load.wait_en", en(), 6'b001000);
            chk("load.wait_sel", sel(), 7'b01_00_00_0);
        end
        cyc; data_ready = 1'b1; #1;
        chk("load.rd_st", state_dbg, 8);
        chk("load.rd_en", en(), 6'b001000);
        cyc; #1;
        chk("load.wb_st", state_dbg, 9);
        chk("load.wb_en", en(), 6'b000011);
        chk("load.wb_sel", sel(), 7'b00_00_01_0);
        cyc; #1;
        chk("load.instret", instret, 2);

        // beq taken, comparator drops in BR_TGT: latched taken wins
        fetch_decode(7'b1100011, "beq1");
        branch_taken = 1'b1; #1;
        chk("beq1.cmp_st", state_dbg, 11);
        chk("beq1.cmp_sel", sel(), 7'b00_01_00_0);
        chk("beq1.cmp_en", en(), 0);
        cyc; branch_taken = 1'b0; #1;
        chk("beq1.tgt_st", state_dbg, 12);
        chk("beq1.tgt_sel", sel(), 7'b11_00_00_1);
        chk("beq1.tgt_en", en(), 6'b000001);
        cyc;
        fetch_decode(7'b1100011, "beq0");
        branch_taken = 1'b0; #1;
        chk("beq0.cmp_st", state_dbg, 11);
        cyc; branch_taken = 1'b1; #1;
        chk("beq0.tgt_sel", sel(), 7'b11_00_00_0);
        chk("beq0.tgt_en", en(), 6'b000001);
        cyc; branch_taken = 1'b0; #1;
        chk("beq.instret", instret, 4);

        // JAL then AUIPC: 3 + 4 cycles
        fetch_decode(7'b1101111, "jal");
        #1;
        chk("jal.st", state_dbg, 13);
        chk("jal.sel", sel(), 7'b11_00_10_1);
        chk("jal.en", en(), 6'b000011);
        cyc;
        fetch_decode(7'b0010111, "auipc");
        #1;
        chk("auipc.exec_st", state_dbg, 5);
        chk("auipc.exec_sel", sel(), 7'b11_00_00_0);
        cyc; #1;
        chk("auipc.wb_st", state_dbg, 6);
        chk("auipc.wb_sel", sel(), 7'b11_00_00_0);
        chk("auipc.wb_en", en(), 6'b000011);
        cyc; #1;
        chk("jal_auipc.instret", instret, 6);

        // Store, zero-wait: completion PCWrite in MEM_WR
        fetch_decode(7'b0100011, "store");
        data_ready = 1'b1; #1;
        chk("store.adr_st", state_dbg, 7);
        cyc; #1;
        chk("store.wr_st", state_dbg, 10);
        chk("store.wr_en", en(), 6'b000101);
        chk("store.wr_sel", sel(), 7'b01_00_00_0);
        cyc; #1;
        chk("store.done_st", state_dbg, 0);
        chk("store.instret", instret, 7);

        // JALR and LUI
        fetch_decode(7'b1100111, "jalr");
        #1;
        chk("jalr.st", state_dbg, 14);
        chk("jalr.sel", sel(), 7'b01_00_10_1);
        chk("jalr.en", en(), 6'b000011);
        cyc;
        fetch_decode(7'b0110111, "lui");
        #1;
        chk("lui.exec_sel", sel(), 7'b01_11_00_0);
        cyc; #1;
        chk("lui.wb_sel", sel(), 7'b01_11_00_0);
        cyc; #1;
        chk("lui.instret", instret, 9);

        // Illegal opcode: sticky TRAP with everything quiet
        fetch_decode(7'b1111111, "trap");
        data_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("trap.st", state_dbg, 15);
            chk("trap.illegal", {31'd0, illegal}, 1);
            chk("trap.en", en(), 0);
            chk("trap.instret", instret, 9);
            cyc;
        end
        rst = 1'b1;
        cyc; rst = 1'b0; instr_ready = 1'b0; #1;
        chk("rst.illegal", {31'd0, illegal}, 0);
        chk("rst.st", state_dbg, 0);
        chk("rst.en", en(), 6'b100000);
        chk("rst.instret", instret, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
